// File: rtl/ad_spi_pkg.sv
// Shared definitions for the AD79xx/AD55xx SPI converter blocks:
// FSM state encoding, default 100 MHz timing and the sample formatter.
package ad_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

  localparam int SCLK_DIV_100M    = 2;
  localparam int CONV_CYCLES_100M = 71;
  localparam int SAMPLE_DIV_100M  = 200;
  localparam int SAMPLE_BITS      = 16;

  // Straight binary to two's complement is just an MSB flip.
  function automatic logic [SAMPLE_BITS-1:0] format_sample(
    input logic [SAMPLE_BITS-1:0] raw,
    input logic                   to_signed
  );
    format_sample = to_signed ? {~raw[SAMPLE_BITS-1], raw[SAMPLE_BITS-2:0]} : raw;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: sclk idles low, toggles every SCLK_DIV cycles
// while run is high, and flags the cycle whose edge drives each transition.
module spi_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_strobe,
  output logic fall_strobe
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          half_done;

  assign half_done   = run && (div_cnt == DIV_LAST);
  assign rise_strobe = half_done && !sclk;
  assign fall_strobe = half_done && sclk;

  // Holding the divider cleared while idle restarts it on every rising run.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/ad7980_axis_source_sar.sv
// AD7980-class SAR ADC reader (3-wire CS mode) presenting one 16-bit sample
// per sample period as an AXI-Stream master with a one-entry output register.
module ad7980_axis_source_sar
  import ad_spi_pkg::*;
#(
  parameter int SCLK_DIV    = SCLK_DIV_100M,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_100M,
  parameter int CONV_CYCLES = CONV_CYCLES_100M,
  parameter bit SIGNED_OUT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_cnv,
  output logic        adc_sclk,
  input  logic        adc_sdo,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] overrun_cnt,
  output logic        busy
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CONV_LOAD   = CW'(CONV_CYCLES - 1);

  if (SAMPLE_DIV < CONV_CYCLES + 32 * SCLK_DIV + 4) begin : g_bad_sample_div
    $error("SAMPLE_DIV too short for one conversion plus a 16-bit read");
  end
  if (SCLK_DIV < 1 || CONV_CYCLES < 1) begin : g_bad_timing
    $error("SCLK_DIV and CONV_CYCLES must be at least 1");
  end

  spi_state_t    state, next_state;
  logic [PW-1:0] period_cnt;
  logic [CW-1:0] conv_cnt;
  logic [15:0]   shift_reg;
  logic [4:0]    bit_cnt;
  logic          read_done;
  logic          sample_tick;
  logic          sclk_rise, sclk_fall;
  logic          out_free, load_sample, drop_sample;

  assign sample_tick = (period_cnt == '0) && enable;
  assign busy        = (state != ST_IDLE);
  assign out_free    = !m_axis_tvalid || m_axis_tready;
  assign load_sample = (state == ST_DONE) && out_free;
  assign drop_sample = (state == ST_DONE) && !out_free;

  spi_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk (
    .clk        (clk),
    .rst        (rst),
    .run        (state == ST_READ),
    .sclk       (adc_sclk),
    .rise_strobe(sclk_rise),
    .fall_strobe(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // read_done marks the first low cycle after the 16th SCLK pulse.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (sample_tick)     next_state = ST_CONV;
      ST_CONV: if (conv_cnt == '0)  next_state = ST_READ;
      ST_READ: if (read_done)       next_state = ST_DONE;
      ST_DONE:                      next_state = ST_IDLE;
      default:                      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      conv_cnt   <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      read_done  <= 1'b0;
      adc_cnv    <= 1'b0;
    end else begin
      period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + PW'(1);
      read_done  <= (state == ST_READ) && sclk_fall && (bit_cnt == '0);
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            adc_cnv  <= 1'b1;
            conv_cnt <= CONV_LOAD;
          end
        end
        ST_CONV: begin
          if (conv_cnt == '0) begin
            adc_cnv <= 1'b0;
            bit_cnt <= 5'd16;
          end else begin
            conv_cnt <= conv_cnt - CW'(1);
          end
        end
        ST_READ: begin
          // SDO changes on SCLK falling edges, so capture as SCLK is driven high.
          if (sclk_rise && bit_cnt != '0) begin
            shift_reg <= {shift_reg[14:0], adc_sdo};
            bit_cnt   <= bit_cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (load_sample) begin
        m_axis_tdata  <= format_sample(shift_reg, SIGNED_OUT);
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop_sample && overrun_cnt != 16'hFFFF) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ad7980_axis_source_sar.sv
// Directed bench for ad7980_axis_source_sar: ADC bus model, vector table for
// word formatting and timing, plus back-pressure, saturation and reset sequences.
module tb_ad7980_axis_source_sar;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_sdo = 1'b0;
  logic        m_axis_tready = 1'b1;
  logic        adc_cnv, adc_sclk, m_axis_tvalid, busy;
  logic [15:0] m_axis_tdata, overrun_cnt;
  logic        raw_cnv, raw_sclk, raw_tvalid, raw_busy;
  logic [15:0] raw_tdata, raw_overrun;

  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_sh = 16'h0000;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] code;
    logic [15:0] exp_signed;
    logic [15:0] exp_raw;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad7980_axis_source_sar #(
    .SCLK_DIV(2), .SAMPLE_DIV(200), .CONV_CYCLES(71), .SIGNED_OUT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_cnv(adc_cnv), .adc_sclk(adc_sclk), .adc_sdo(adc_sdo),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  ad7980_axis_source_sar #(
    .SCLK_DIV(2), .SAMPLE_DIV(200), .CONV_CYCLES(71), .SIGNED_OUT(1'b0)
  ) dut_raw (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_cnv(raw_cnv), .adc_sclk(raw_sclk), .adc_sdo(adc_sdo),
    .m_axis_tdata(raw_tdata), .m_axis_tvalid(raw_tvalid),
    .m_axis_tready(m_axis_tready), .overrun_cnt(raw_overrun), .busy(raw_busy)
  );

  // ADC model: MSB appears when CNV falls, next bit after each SCLK fall.
  always @(negedge adc_cnv) begin
    adc_sh  <= adc_word;
    adc_sdo <= adc_word[15];
  end
  always @(negedge adc_sclk) begin
    if (!adc_cnv) begin
      adc_sdo <= adc_sh[14];
      adc_sh  <= {adc_sh[14:0], 1'b0};
    end
  end

  // Per-frame waveform statistics, sampled mid-cycle.
  logic cnv_q = 1'b0, sclk_q = 1'b0;
  int cnv_len = 0, rises = 0, phase_err = 0, run_len = 0, idle_err = 0;
  always @(negedge clk) begin
    if (adc_cnv && !cnv_q) begin
      cnv_len = 0; rises = 0; phase_err = 0;
    end
    if (adc_cnv) cnv_len++;
    if (adc_sclk != sclk_q) begin
      if (sclk_q && run_len != 2) phase_err++;
      if (!sclk_q && rises > 0 && run_len != 2) phase_err++;
      if (adc_sclk) rises++;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (adc_cnv && adc_sclk) phase_err++;
    if (!rst && !busy && (adc_cnv || adc_sclk)) idle_err++;
    cnv_q  = adc_cnv;
    sclk_q = adc_sclk;
  end

  task automatic applyStimulus(input logic [15:0] word, input logic ready, input logic en);
    adc_word      = word;
    m_axis_tready = ready;
    enable        = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cnv_rise(input int max_cyc, output bit ok, output int tick);
    logic prev;
    prev = adc_cnv;
    ok   = 1'b0;
    tick = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (adc_cnv && !prev) begin
        ok   = 1'b1;
        tick = cyc - 1;
        break;
      end
      prev = adc_cnv;
    end
  endtask

  task automatic hold_check(input int n, input logic [15:0] exp, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!m_axis_tvalid || m_axis_tdata !== exp) bad++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, " adc_cnv"}, 32'(adc_cnv), 32'd0);
    checkOutput({tag, " adc_sclk"}, 32'(adc_sclk), 32'd0);
    checkOutput({tag, " tvalid"}, 32'(m_axis_tvalid), 32'd0);
    checkOutput({tag, " tdata"}, 32'(m_axis_tdata), 32'd0);
    checkOutput({tag, " overrun"}, 32'(overrun_cnt), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int at, r_cyc, c0, tick, bad, events;

    vecs[0] = '{16'hA5C3, 16'h25C3, 16'hA5C3};
    vecs[1] = '{16'h0000, 16'h8000, 16'h0000};
    vecs[2] = '{16'h8000, 16'h0000, 16'h8000};
    vecs[3] = '{16'hFFFF, 16'h7FFF, 16'hFFFF};
    vecs[4] = '{16'h1234, 16'h9234, 16'h1234};

    rst = 1'b1;
    applyStimulus(vecs[0].code, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    r_cyc = cyc;
    rst = 1'b0;

    // Table: formatting, latency/cadence and per-frame waveform.
    for (int i = 0; i < 5; i++) begin
      wait_valid(400, ok, at);
      checkOutput($sformatf("vec%0d found", i), 32'(ok), 32'd1);
      checkOutput($sformatf("vec%0d tdata", i), 32'(m_axis_tdata), 32'(vecs[i].exp_signed));
      checkOutput($sformatf("vec%0d raw tdata", i), 32'(raw_tdata), 32'(vecs[i].exp_raw));
      checkOutput($sformatf("vec%0d latency", i), 32'(at - r_cyc), 32'(138 + 200 * i));
      checkOutput($sformatf("vec%0d cnv len", i), 32'(cnv_len), 32'd71);
      checkOutput($sformatf("vec%0d sclk rises", i), 32'(rises), 32'd16);
      checkOutput($sformatf("vec%0d phase err", i), 32'(phase_err), 32'd0);
      if (i < 4) applyStimulus(vecs[i + 1].code, 1'b1, 1'b1);
    end

    // Back-pressure over three sample periods.
    @(negedge clk);
    checkOutput("bp tvalid drained", 32'(m_axis_tvalid), 32'd0);
    applyStimulus(16'h0F0F, 1'b0, 1'b1);
    wait_valid(400, ok, c0);
    checkOutput("bp first found", 32'(ok), 32'd1);
    checkOutput("bp first tdata", 32'(m_axis_tdata), 32'h8F0F);
    applyStimulus(16'h1111, 1'b0, 1'b1);
    hold_check(200, 16'h8F0F, bad);
    checkOutput("bp hold1 stable", 32'(bad), 32'd0);
    checkOutput("bp overrun1", 32'(overrun_cnt), 32'd1);
    applyStimulus(16'h2222, 1'b0, 1'b1);
    hold_check(200, 16'h8F0F, bad);
    checkOutput("bp hold2 stable", 32'(bad), 32'd0);
    checkOutput("bp overrun2", 32'(overrun_cnt), 32'd2);
    applyStimulus(16'h7ABC, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp accepted", 32'(m_axis_tvalid), 32'd0);
    wait_valid(300, ok, at);
    checkOutput("bp next found", 32'(ok), 32'd1);
    checkOutput("bp next cadence", 32'(at - c0), 32'd600);
    checkOutput("bp next tdata", 32'(m_axis_tdata), 32'hFABC);
    checkOutput("bp overrun kept", 32'(overrun_cnt), 32'd2);

    // Enable dropped mid-sample: current sample still delivered, then quiet.
    applyStimulus(16'hC001, 1'b1, 1'b1);
    wait_cnv_rise(300, ok, tick);
    checkOutput("en cnv rise", 32'(ok), 32'd1);
    repeat (50) @(negedge clk);
    applyStimulus(16'hC001, 1'b1, 1'b0);
    wait_valid(200, ok, at);
    checkOutput("en found", 32'(ok), 32'd1);
    checkOutput("en latency", 32'(at - tick), 32'd138);
    checkOutput("en tdata", 32'(m_axis_tdata), 32'h4001);
    events = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_axis_tvalid || adc_cnv || busy) events++;
    end
    checkOutput("en quiet", 32'(events), 32'd0);

    // Overrun saturation from a preloaded 16'hFFFE.
    applyStimulus(16'h3C3C, 1'b0, 1'b1);
    force dut.overrun_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.overrun_cnt;
    wait_valid(450, ok, at);
    checkOutput("sat found", 32'(ok), 32'd1);
    checkOutput("sat tdata", 32'(m_axis_tdata), 32'hBC3C);
    checkOutput("sat load no count", 32'(overrun_cnt), 32'hFFFE);
    applyStimulus(16'h4444, 1'b0, 1'b1);
    hold_check(200, 16'hBC3C, bad);
    checkOutput("sat hold1 stable", 32'(bad), 32'd0);
    checkOutput("sat reach max", 32'(overrun_cnt), 32'hFFFF);
    applyStimulus(16'h5555, 1'b0, 1'b1);
    hold_check(200, 16'hBC3C, bad);
    checkOutput("sat hold2 stable", 32'(bad), 32'd0);
    checkOutput("sat no wrap", 32'(overrun_cnt), 32'hFFFF);

    // Reset 100 cycles into a frame, with a sample still held.
    applyStimulus(16'h6666, 1'b0, 1'b1);
    wait_cnv_rise(300, ok, tick);
    checkOutput("rst cnv rise", 32'(ok), 32'd1);
    repeat (99) @(negedge clk);
    checkOutput("rst busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    r_cyc = cyc;
    applyStimulus(16'hDEAD, 1'b1, 1'b1);
    rst = 1'b0;
    wait_valid(400, ok, at);
    checkOutput("post rst found", 32'(ok), 32'd1);
    checkOutput("post rst latency", 32'(at - r_cyc), 32'd138);
    checkOutput("post rst tdata", 32'(m_axis_tdata), 32'h5EAD);
    checkOutput("post rst raw tdata", 32'(raw_tdata), 32'hDEAD);
    checkOutput("idle lines low", 32'(idle_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
